dac_tx_spi: RTL and testbench
=============================

DAC_TX_SPI -- requirements
Module: dac_tx_spi

Interface
REQ-001 SHALL have parameter cant_bits, default 25, width of the signed two's-complement filter output sample.
REQ-002 SHALL have parameter dac_bits, default 12, DAC resolution; legal range 1 to min(cant_bits, 16).
REQ-003 SHALL have parameter clk_div, default 2, SCLK half-period in clk cycles; minimum 1.
REQ-004 SHALL have port clk input 1, the single system clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst input 1; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port y input cant_bits, the filtered sample, valid when rx_2 is high.
REQ-007 SHALL have port rx_2 input 1, a one-cycle sample strobe from the filter.
REQ-008 SHALL have port sclk output 1, the DAC serial clock.
REQ-009 SHALL have port sync_n output 1, the active-low frame sync.
REQ-010 SHALL have port sdata output 1, serial data, MSB first.
REQ-011 SHALL have port busy output 1, high from frame start until return to IDLE.
REQ-012 SHALL have port overrun output 1, sticky flag for a lost sample.
REQ-013 SHALL have port done output 1, one-cycle pulse when sync_n rises at frame end.

Function
REQ-014 SHALL form the DAC code as y[cant_bits-1 -: dac_bits] with MSB inverted (offset binary), truncating the LSBs with no rounding.
REQ-015 SHALL form a 16-bit frame of {(16-dac_bits) zero bits, code}; with defaults this is 4'b0000 followed by the 12-bit code.
REQ-016 SHALL hold one pending sample in a one-deep buffer with a valid bit; rx_2 SHALL write the buffer and set valid in the same cycle.
REQ-017 SHALL, if rx_2 arrives while the buffer is valid and not yet consumed, overwrite the buffer with the newest sample and set overrun; overrun SHALL clear only on reset.
REQ-018 SHALL implement the states IDLE, LOAD, SHIFT and GAP.
REQ-019 IDLE: sync_n=1, sclk=1, busy=0; SHALL go to LOAD when the buffer is valid.
REQ-020 LOAD: SHALL copy the buffer into the shift register, clear valid, and set busy=1; SHALL last one cycle.
REQ-021 SHIFT: sync_n SHALL be 0 and 16 bits SHALL be sent.
REQ-022 SHIFT: each bit SHALL last 2*clk_div cycles, with sclk high for the first clk_div cycles and low for the second.
REQ-023 SHIFT: sdata SHALL change only on the clk edge where sclk goes high, so the DAC samples on the falling sclk edge.
REQ-024 SHIFT: sync_n SHALL fall on the same edge as the first sclk-high phase; SHIFT SHALL last exactly 32*clk_div cycles.
REQ-025 GAP: sync_n=1 and sclk=1 for 2*clk_div cycles; done SHALL pulse in the first GAP cycle.
REQ-026 On GAP exit, SHALL go to LOAD if the buffer is valid, else to IDLE.
REQ-027 Latency SHALL be fixed: rx_2 high in IDLE at cycle t gives LOAD at t+1 and the sync_n fall at t+2.
REQ-028 SHALL treat rx_2 in the same cycle that LOAD consumes the buffer as a new pending sample, with no overrun.
REQ-029 SHALL keep a bit counter and a divider counter wide enough for 16 bits and clk_div, with no wrap before the frame end.
REQ-030 SHALL drive sdata=0 outside SHIFT.

Reset
REQ-031 SHALL, when rst is low, asynchronously force state=IDLE, sclk=1, sync_n=1, sdata=0, busy=0, done=0, overrun=0, buffer valid=0, and clear the shift register and counters.
REQ-032 SHALL abort a frame in progress on mid-frame reset, with sync_n high immediately and no done pulse.
REQ-033 SHALL start on the first rx_2 after rst deasserts, with no extra warm-up cycles.

Verification (defaults, clk_div=2)
REQ-034 y=25'h0000000 strobed in IDLE -> sync_n falls 2 cycles later; frame 16'h0800; sync_n low 64 cycles; done one cycle.
REQ-035 y=25'h0FFFFFF -> frame 16'h0FFF; y=25'h1000000 -> frame 16'h0000; y=25'h1FFFFFF -> frame 16'h07FF.
REQ-036 Three strobes within one frame (A, then B, then C) -> A sent, C sent next, B lost, overrun=1 and stays 1.
REQ-037 Strobe during GAP -> next frame starts directly via LOAD with no IDLE cycle; overrun stays 0.
REQ-038 rst low at bit 7 of a frame -> all outputs at reset values asynchronously; no done; the next strobe produces a full correct frame.
REQ-039 Sweep clk_div=1 and clk_div=5 -> bit period 2 and 10 cycles; sclk duty 50%; sdata stable across every falling sclk edge.

Source files
------------

// File: rtl/dac_tx_spi.sv
// DAC SPI transmitter: top dac_bits of a signed sample become a 16-bit offset-binary frame, MSB first.
// Two cycles from strobe to the sync_n fall; one pending sample is held, and a newer one overwrites it and sets overrun.
module dac_tx_spi #(
  parameter int cant_bits = 25,
  parameter int dac_bits  = 12,
  parameter int clk_div   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [cant_bits-1:0] y,
  input  logic                 rx_2,
  output logic                 sclk,
  output logic                 sync_n,
  output logic                 sdata,
  output logic                 busy,
  output logic                 overrun,
  output logic                 done
);

  localparam int               DIV_W    = $clog2(2 * clk_div + 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(clk_div);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * clk_div - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [3:0]       BIT_LAST = 4'd15;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [3:0]          bit_q, bit_d;
  logic [15:0]         shift_q, shift_d;
  logic [15:0]         buf_q, buf_d;
  logic                vld_q, vld_d;
  logic                ovr_q, ovr_d;
  logic                sclk_q, sclk_d;
  logic                sync_n_q, sync_n_d;
  logic                sdata_q, sdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [dac_bits-1:0] code_w;
  logic [15:0]         frame_w;
  logic                consume_w;
  logic                pending_w;

  // Low sample bits are deliberately truncated; fold them here so they are not flagged as dangling.
  logic unused_y_bits;
  assign unused_y_bits = ^y;

  always_comb begin
    code_w             = y[cant_bits-1 -: dac_bits];
    code_w[dac_bits-1] = ~code_w[dac_bits-1];
    frame_w            = 16'(code_w);
  end

  assign consume_w = (state_q == LOAD);
  // A strobe this cycle is already in the buffer by the time LOAD reads it.
  assign pending_w = vld_q | rx_2;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (pending_w) state_d = LOAD;
      end
      LOAD: begin
        shift_d = buf_q;
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = pending_w ? LOAD : IDLE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
    endcase
  end

  always_comb begin
    buf_d = buf_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (consume_w) vld_d = 1'b0;
    if (rx_2) begin
      buf_d = frame_w;
      vld_d = 1'b1;
      if (vld_q && !consume_w) ovr_d = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they switch cleanly on the clk edge.
  always_comb begin
    sclk_d   = !((state_d == SHIFT) && (div_d >= DIV_HALF));
    sync_n_d = (state_d != SHIFT);
    sdata_d  = (state_d == SHIFT) && shift_d[15];
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == SHIFT) && (state_d == GAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      buf_q    <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      sdata_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      buf_q    <= buf_d;
      vld_q    <= vld_d;
      ovr_q    <= ovr_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      sdata_q  <= sdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk    = sclk_q;
  assign sync_n  = sync_n_q;
  assign sdata   = sdata_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dac_tx_spi.sv
// Bench for dac_tx_spi: three instances (clk_div 2, 1, 5) with separate strobes and shared sample bus.
module tb_dac_tx_spi;

  localparam int CB = 25;
  localparam int DB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [CB-1:0] y_r;
  logic [2:0]    rx2_v;
  logic [2:0]    sclk_v, sync_v, sdata_v, busy_v, ovr_v, done_v;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  dac_tx_spi #(.cant_bits(CB), .dac_bits(DB), .clk_div(2)) u_div2 (
    .clk(clk), .rst(rst), .y(y_r), .rx_2(rx2_v[0]), .sclk(sclk_v[0]), .sync_n(sync_v[0]),
    .sdata(sdata_v[0]), .busy(busy_v[0]), .overrun(ovr_v[0]), .done(done_v[0]));
  dac_tx_spi #(.cant_bits(CB), .dac_bits(DB), .clk_div(1)) u_div1 (
    .clk(clk), .rst(rst), .y(y_r), .rx_2(rx2_v[1]), .sclk(sclk_v[1]), .sync_n(sync_v[1]),
    .sdata(sdata_v[1]), .busy(busy_v[1]), .overrun(ovr_v[1]), .done(done_v[1]));
  dac_tx_spi #(.cant_bits(CB), .dac_bits(DB), .clk_div(5)) u_div5 (
    .clk(clk), .rst(rst), .y(y_r), .rx_2(rx2_v[2]), .sclk(sclk_v[2]), .sync_n(sync_v[2]),
    .sdata(sdata_v[2]), .busy(busy_v[2]), .overrun(ovr_v[2]), .done(done_v[2]));

  typedef struct {
    logic [CB-1:0] y;
    logic [15:0]   frame;
  } vec_t;

  function automatic int div_of(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 1 : 5;
  endfunction

  // Offset binary is the signed top-bits value plus half scale.
  function automatic logic [15:0] model_frame(input logic [CB-1:0] yv);
    int signed s;
    int        code;
    s    = int'($signed(yv));
    code = (s >>> (CB - DB)) + (1 << (DB - 1));
    return 16'(code);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic strobe(input int sel, input logic [CB-1:0] val);
    y_r        = val;
    rx2_v[sel] = 1'b1;
    tick;
    rx2_v[sel] = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int g;
    g = 0;
    while (busy_v[sel] && g < 1000) begin
      tick;
      g++;
    end
    if (busy_v[sel]) fail_now($sformatf("idle_timeout_%0d", sel));
    tick;
  endtask

  task automatic capture(input int sel, output logic [15:0] frm, output int lowc,
                         output int shape, output int stab, output int dones, output logic done_first);
    int   d, guard, run;
    logic ps, pd;
    d = div_of(sel);
    guard = 0; run = 0;
    frm = '0; lowc = 0; shape = 0; stab = 0; dones = 0; done_first = 1'b0;
    while (sync_v[sel] && guard < 400) begin
      tick;
      guard++;
    end
    if (sync_v[sel]) begin
      fail_now($sformatf("sync_fall_timeout_%0d", sel));
      return;
    end
    if (!sclk_v[sel]) shape++;
    ps = sclk_v[sel];
    pd = sdata_v[sel];
    while (!sync_v[sel] && lowc < 1000) begin
      if (done_v[sel]) dones++;
      if (sclk_v[sel] != ps) begin
        if (run != d) shape++;
        if (ps) begin
          if (sdata_v[sel] != pd) stab++;
          frm = {frm[14:0], pd};
        end
        run = 0;
      end
      run++;
      ps = sclk_v[sel];
      pd = sdata_v[sel];
      lowc++;
      tick;
    end
    if (run != d) shape++;
    done_first = done_v[sel];
    for (int i = 0; i < 2 * d; i++) begin
      if (done_v[sel]) dones++;
      if (!sclk_v[sel] || sdata_v[sel] || !busy_v[sel] || !sync_v[sel]) shape++;
      tick;
    end
  endtask

  task automatic run_frame(input int sel, input logic [15:0] exp, input string tag);
    logic [15:0] frm;
    int          lowc, shape, stab, dones;
    logic        df;
    capture(sel, frm, lowc, shape, stab, dones, df);
    check({tag, "_frame"}, 32'(frm), 32'(exp));
    check({tag, "_sync_low_cycles"}, lowc, 32 * div_of(sel));
    check({tag, "_sclk_shape"}, shape, 0);
    check({tag, "_sdata_stable"}, stab, 0);
    check({tag, "_done_first_gap"}, 32'(df), 1);
    check({tag, "_done_count"}, dones, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [CB-1:0] a, b, c, yv;
    int dcnt;

    vecs[0] = '{25'h0000000, 16'h0800};
    vecs[1] = '{25'h0FFFFFF, 16'h0FFF};
    vecs[2] = '{25'h1000000, 16'h0000};
    vecs[3] = '{25'h1FFFFFF, 16'h07FF};
    vecs[4] = '{25'h0ABCDEF, 16'h0D5E};
    vecs[5] = '{25'h1234567, 16'h011A};

    rst = 1'b0; y_r = '0; rx2_v = '0;
    repeat (3) tick;
    check("rst_sclk", 32'(sclk_v), 32'h7);
    check("rst_sync_n", 32'(sync_v), 32'h7);
    check("rst_sdata", 32'(sdata_v), 0);
    check("rst_busy", 32'(busy_v), 0);
    check("rst_overrun", 32'(ovr_v), 0);
    check("rst_done", 32'(done_v), 0);
    rst = 1'b1;
    tick;

    // First strobe after reset release: LOAD next cycle, sync_n falls the one after.
    strobe(0, 25'h0000000);
    check("lat_load_busy", 32'(busy_v[0]), 1);
    check("lat_load_sync_n", 32'(sync_v[0]), 1);
    tick;
    check("lat_sync_fall", 32'(sync_v[0]), 0);
    run_frame(0, 16'h0800, "first");

    for (int i = 0; i < 6; i++) begin
      wait_idle(0);
      strobe(0, vecs[i].y);
      check($sformatf("vec%0d_busy", i), 32'(busy_v[0]), 1);
      run_frame(0, vecs[i].frame, $sformatf("vec%0d", i));
    end

    // Strobe in the LOAD cycle is a fresh pending sample, not an overrun.
    wait_idle(0);
    a = 25'h0ABCDEF; b = 25'h1234567;
    strobe(0, a);
    strobe(0, b);
    run_frame(0, model_frame(a), "load_a");
    run_frame(0, model_frame(b), "load_b");
    check("load_no_overrun", 32'(ovr_v[0]), 0);

    // Strobe during GAP chains straight into LOAD.
    wait_idle(0);
    a = 25'h0123456; c = 25'h1F00F0F;
    strobe(0, a);
    fork
      run_frame(0, model_frame(a), "gap_a");
      begin
        dcnt = 0;
        while (!done_v[0] && dcnt < 300) begin
          tick;
          dcnt++;
        end
        if (!done_v[0]) fail_now("gap_done_wait");
        strobe(0, c);
      end
    join
    check("gap_load_busy", 32'(busy_v[0]), 1);
    check("gap_load_sync_n", 32'(sync_v[0]), 1);
    run_frame(0, model_frame(c), "gap_c");
    check("gap_no_overrun", 32'(ovr_v[0]), 0);

    // Three strobes in one frame: B is lost, C follows A.
    wait_idle(0);
    a = 25'h0654321; b = 25'h1111111; c = 25'h0EEEEEE;
    strobe(0, a);
    fork
      run_frame(0, model_frame(a), "ovr_a");
      begin
        repeat (10) tick;
        strobe(0, b);
        repeat (10) tick;
        strobe(0, c);
      end
    join
    check("ovr_set", 32'(ovr_v[0]), 1);
    run_frame(0, model_frame(c), "ovr_c");
    wait_idle(0);
    check("ovr_sticky", 32'(ovr_v[0]), 1);
    rst = 1'b0;
    #1;
    check("ovr_cleared_by_reset", 32'(ovr_v[0]), 0);
    tick;
    rst = 1'b1;
    tick;

    // Reset in the low sclk phase of bit 7.
    strobe(0, 25'h0FFFFFF);
    tick;
    repeat (7 * 4 + 2) tick;
    check("mid_pre_sync_n", 32'(sync_v[0]), 0);
    check("mid_pre_sclk", 32'(sclk_v[0]), 0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_sync_n", 32'(sync_v[0]), 1);
    check("mid_rst_sclk", 32'(sclk_v[0]), 1);
    check("mid_rst_sdata", 32'(sdata_v[0]), 0);
    check("mid_rst_busy", 32'(busy_v[0]), 0);
    dcnt = 0;
    repeat (3) begin
      tick;
      dcnt += int'(done_v[0]);
    end
    rst = 1'b1;
    repeat (10) begin
      tick;
      dcnt += int'(done_v[0]);
    end
    check("mid_rst_no_done", dcnt, 0);
    strobe(0, 25'h1000000);
    run_frame(0, 16'h0000, "post_rst");

    // Random samples across all three divider settings.
    for (int i = 0; i < 12; i++) begin
      int sel;
      sel = i % 3;
      yv  = CB'($urandom);
      wait_idle(sel);
      strobe(sel, yv);
      run_frame(sel, model_frame(yv), $sformatf("rnd%0d_div%0d", i, div_of(sel)));
    end
    check("div1_no_overrun", 32'(ovr_v[1]), 0);
    check("div5_no_overrun", 32'(ovr_v[2]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
